bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end that produces the 1-bit input stream `x` for the sequence-detecting Mealy FSM. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per `clk`. A one-entry holding register lets consecutive words stream with no idle bits between them. When no word is pending, it drives a constant idle level so the downstream FSM sees a defined input every cycle.

## Interface
- `WIDTH`, default 8: bits per word, at least 2.
- `IDLE_BIT`, default 1'b0: value driven on `x` when no word is shifting.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `clk`  in  1: single clock; all state updates on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  WIDTH: word to serialize.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: the block can accept a word this cycle.
- `x`  out  1: serial bit to the downstream FSM; registered.
- `x_active`  out  1: `x` carries a data bit this cycle, not idle; registered.
- `frame_start`  out  1: `x` carries the first bit of a word this cycle; registered.
- `words_sent`  out  16: count of fully shifted words; wraps 16'hFFFF to 16'h0000.

## Operation
- State encoding:
  - IDLE: shift register empty; `x`=IDLE_BIT, `x_active`=0.
  - SHIFT: a word is being emitted.
- Internal storage:
  - shift register `sr`, WIDTH bits.
  - bit counter `cnt`, $clog2(WIDTH) bits, counting the bits remaining after the current one.
  - holding register `hold` with flag `hold_full`.
- `in_ready` = !`hold_full`. It is combinational and independent of `in_valid`.
- A word is accepted when `in_valid` && `in_ready` at a posedge. Its destination depends on state:
  - IDLE: load into `sr`, set `cnt`=WIDTH-1, go to SHIFT.
  - SHIFT with `cnt`=0 (last bit on `x`): bypass `hold` and load straight into `sr`; stay in SHIFT.
  - SHIFT with `cnt`≠0: write into `hold` and set `hold_full`.
- SHIFT, `cnt`≠0: shift `sr` toward the output end and decrement `cnt`.
- SHIFT, `cnt`=0 (word completes): increment `words_sent`, then choose the next action in this priority:
  - `hold_full`: move `hold` into `sr`, clear `hold_full`, stay in SHIFT.
  - otherwise, a word accepted this cycle: that word is loaded (bypass case above).
  - otherwise: go to IDLE.
- Same-edge events: filling `hold` and draining it never happen on the same edge. `in_ready`=0 whenever `hold_full`=1.
- `x`, `x_active` and `frame_start` are registered from next-state values, so they describe the bit currently being driven.
- Reset while a word is in flight: the in-flight word and any held word are discarded, not flushed.

## Timing
- Reset values, effective from the first posedge with `rst`=1:
  - state=IDLE, `hold_full`=0, `cnt`=0, `words_sent`=0
  - `x`=IDLE_BIT, `x_active`=0, `frame_start`=0
- While `rst`=1, `in_valid` is ignored and no word is accepted. `in_ready` may read 1.
- Latency for a word accepted at edge N:
  - first bit on `x` in the cycle after edge N.
  - `frame_start`=1 in that same cycle.
  - last bit on `x` in the cycle after edge N+WIDTH-1.
- `words_sent` increments at the edge that ends the last bit's cycle.
- Throughput: one word per WIDTH cycles, gapless when the upstream keeps `hold` filled.
- `in_data` is sampled only on the accepting edge. The upstream may change it freely afterwards.

## Structure
- Shared package `serializer_pkg`:
  - state localparams `SER_IDLE`=1'b0, `SER_SHIFT`=1'b1.
  - default width constant `SER_WIDTH`=8.
- No sub-module. The holding register and shift register are small enough to stay inline.
- Top-level pairing: `x` connects directly to the FSM's `x`, with `clk` and `rst` shared.

## Test plan
- Reset then idle: hold `rst` for 2 cycles, `in_valid`=0 for 20 cycles -> `x`=0, `x_active`=0, `in_ready`=1, `words_sent`=0 throughout.
- Single word: WIDTH=8, MSB_FIRST=1, accept 8'hB4 at edge N -> `x` = 1,0,1,1,0,1,0,0 in cycles N+1..N+8; `frame_start` high only in cycle N+1; `words_sent`=1; then `x`=0, `x_active`=0.
- Back-to-back: present 8'hFF, 8'h00, 8'hA5 with `in_valid` held high -> 24 consecutive active bits with no gap; `in_ready` low while `hold` is full; `frame_start` at offsets 0, 8, 16.
- Bypass on last bit: raise `in_valid` with 8'h81 only in the last-bit cycle of a previous word -> next cycle shows the 8'h81 first bit with `frame_start`=1; `hold_full` never set.
- Reset mid-word: assert `rst` after 3 bits of 8'hF0 with a word in `hold` -> next cycle `x`=0, `x_active`=0, `words_sent` unchanged from 0; the held word is never emitted.
- Counter wrap: preload via 65535 words, or force `words_sent`=16'hFFFF, then complete one word -> `words_sent`=16'h0000.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared constants and state type for the parallel-to-serial front end.
package serializer_pkg;

    localparam logic        SER_IDLE  = 1'b0;
    localparam logic        SER_SHIFT = 1'b1;
    localparam int unsigned SER_WIDTH = 8;

    typedef enum logic {
        StIdle  = SER_IDLE,
        StShift = SER_SHIFT
    } ser_state_e;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: WIDTH-bit words in over valid/ready, one bit per clock out on x,
// with a one-entry holding register so consecutive words stream without idle bits.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = SER_WIDTH,
    parameter logic        IDLE_BIT  = 1'b0,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_active,
    output logic             frame_start,
    output logic [15:0]      words_sent
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [15:0]      words_q, words_d;
    logic             x_q, x_d;
    logic             x_active_q, x_active_d;
    logic             frame_start_q, frame_start_d;
    logic             accept;
    logic             load;

    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    assign in_ready = !hold_full_q;
    assign accept   = in_valid && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        words_d     = words_q;
        load        = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    sr_d    = in_data;
                    cnt_d   = CntLast;
                    state_d = StShift;
                    load    = 1'b1;
                end
            end
            StShift: begin
                if (cnt_q != '0) begin
                    sr_d  = shift_once(sr_q);
                    cnt_d = cnt_q - CntW'(1);
                    if (accept) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end else begin
                    words_d = words_q + 16'd1;
                    // A held word takes priority; accept is low whenever hold is full anyway.
                    if (hold_full_q) begin
                        sr_d        = hold_q;
                        cnt_d       = CntLast;
                        hold_full_d = 1'b0;
                        load        = 1'b1;
                    end else if (accept) begin
                        sr_d  = in_data;
                        cnt_d = CntLast;
                        load  = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        x_active_d    = (state_d == StShift);
        x_d           = x_active_d ? out_bit(sr_d) : IDLE_BIT;
        frame_start_d = load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            sr_q          <= '0;
            cnt_q         <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            words_q       <= 16'd0;
            x_q           <= IDLE_BIT;
            x_active_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            words_q       <= words_d;
            x_q           <= x_d;
            x_active_q    <= x_active_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign x_active    = x_active_q;
    assign frame_start = frame_start_q;
    assign words_sent  = words_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: accepted words push expected bits, a monitor pops them.
module tb_bit_serializer;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        x;
    logic        x_active;
    logic        frame_start;
    logic [15:0] words_sent;

    int          tests;
    int          fails;
    logic [1:0]  sb[$];
    logic        ready_low_seen;

    bit_serializer #(
        .WIDTH    (8),
        .IDLE_BIT (1'b0),
        .MSB_FIRST(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .x_active   (x_active),
        .frame_start(frame_start),
        .words_sent (words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {x, frame_start} per bit, MSB first.
    task automatic push_exp(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            sb.push_back({d[7 - i], (i == 0)});
        end
    endtask

    // Entered just after a posedge; returns just after the accepting posedge with in_valid still 1.
    task automatic accept(input logic [7:0] d);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            push_exp(d);
            #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic monitor_loop();
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && !in_ready) ready_low_seen = 1'b1;
            if (!rst && x_active) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_bit: x_active=1 x=%b with empty scoreboard", x);
                end else begin
                    e = sb.pop_front();
                    if ({x, frame_start} !== e) begin
                        fails++;
                        $display("FAIL serial_bit: got x/frame_start %b%b expected %b%b at %0t",
                                 x, frame_start, e[1], e[0], $time);
                    end
                end
            end else if (!rst && sb.size() != 0) begin
                tests++;
                fails++;
                $display("FAIL stream_gap: x_active=0 with %0d bits pending at %0t",
                         sb.size(), $time);
            end
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        ready_low_seen = 1'b0;
        rst            = 1'b1;
        in_valid       = 1'b0;
        in_data        = 8'h00;
        fork
            monitor_loop();
        join_none

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_x", {15'd0, x}, 16'd0);
            check("idle_x_active", {15'd0, x_active}, 16'd0);
            check("idle_in_ready", {15'd0, in_ready}, 16'd1);
            check("idle_words", words_sent, 16'd0);
        end
        @(posedge clk);
        #1;

        // Single word
        accept(8'hB4);
        idle_cycles(12);
        @(negedge clk);
        check("single_words", words_sent, 16'd1);
        check("single_after_x", {15'd0, x}, 16'd0);
        check("single_after_active", {15'd0, x_active}, 16'd0);
        @(posedge clk);
        #1;

        // Back-to-back with in_valid held high
        ready_low_seen = 1'b0;
        accept(8'hFF);
        accept(8'h00);
        accept(8'hA5);
        idle_cycles(30);
        check("b2b_ready_low", {15'd0, ready_low_seen}, 16'd1);
        check("b2b_words", words_sent, 16'd4);
        check("b2b_drained", 16'(sb.size()), 16'd0);

        // Bypass on last bit: offer the next word only during the last-bit cycle
        ready_low_seen = 1'b0;
        accept(8'h3C);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        accept(8'h81);
        idle_cycles(12);
        check("bypass_no_hold", {15'd0, ready_low_seen}, 16'd0);
        check("bypass_words", words_sent, 16'd6);
        check("bypass_drained", 16'(sb.size()), 16'd0);

        // Reset mid-word with a word in hold
        accept(8'hF0);
        accept(8'h0F);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_x", {15'd0, x}, 16'd0);
        check("rst_mid_active", {15'd0, x_active}, 16'd0);
        check("rst_mid_words", words_sent, 16'd0);
        check("rst_mid_ready", {15'd0, in_ready}, 16'd1);
        idle_cycles(20);
        check("rst_mid_words_later", words_sent, 16'd0);

        // Counter wrap
        force dut.words_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.words_q;
        @(negedge clk);
        check("wrap_preload", words_sent, 16'hFFFF);
        @(posedge clk);
        #1;
        accept(8'h55);
        idle_cycles(12);
        check("wrap_words", words_sent, 16'h0000);
        check("final_drained", 16'(sb.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
